ivs_dma_rd_pingpong: RTL and testbench



---
 rtl/ivs_dma_rd_pingpong.sv | 143 ++++++++++++++
 tb/tb_ivs_dma_rd_pingpong.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ivs_dma_rd_pingpong.sv
// ivs_dma_rd_pingpong
//   Sink stage of the IVS DMA read engine. It stores AXI R-channel beats in a
//   two-bank ping-pong buffer. One bank fills from R while the other drains
//   to the IVS datapath through a valid/ready stream. Each bank holds one
//   burst of up to DEPTH beats and records its beat count and rid.
//
// Ports
//   aclk, arst        clock; synchronous active-high reset
//   rvalid/rready     R-channel handshake (rready depends on registered state only)
//   rid/rdata/rlast   R beat id, data and last flag
//   rresp             R response; any value other than 0 sets err_sticky
//   out_valid/ready   output stream handshake
//   out_data          data of the current beat in the draining bank
//   out_last          last beat of the draining bank
//   out_id/out_bank   rid and index of the draining bank
//   bank_full         per-bank occupied flags
//   err_sticky        non-OKAY response seen (sticky)
//   ovf_err           burst ran past DEPTH beats without rlast (sticky)
//   err_clr           clears both error flags; a new error in the same cycle wins
module ivs_dma_rd_pingpong #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned CNT_W  = 7
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rlast,
    input  logic [1:0]        rresp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [3:0]        out_id,
    output logic              out_bank,
    output logic [1:0]        bank_full,
    output logic              err_sticky,
    output logic              ovf_err,
    input  logic              err_clr
);

    localparam int unsigned AW = CNT_W - 1;

    logic [DATA_W-1:0] mem [2][DEPTH];
    logic [CNT_W-1:0]  len [2];
    logic [3:0]        id  [2];

    logic              wsel;
    logic              rsel;
    logic [CNT_W-1:0]  wcnt;
    logic [CNT_W-1:0]  rcnt;

    logic              wr_fire;
    logic              wr_wrap;
    logic              wr_close;
    logic              rd_fire;
    logic              rd_done;

    // rready comes from registered state, so a bank freed this cycle is only
    // writable from the next cycle on.
    assign rready    = !bank_full[wsel];
    assign wr_fire   = rvalid && rready;
    // A full bank without rlast is closed as if rlast were set; the rest of
    // the burst spills into the other bank.
    assign wr_wrap   = (wcnt == CNT_W'(DEPTH - 1));
    assign wr_close  = wr_fire && (rlast || wr_wrap);

    assign out_valid = bank_full[rsel];
    assign out_data  = mem[rsel][rcnt[AW-1:0]];
    assign out_id    = id[rsel];
    assign out_bank  = rsel;
    assign out_last  = out_valid && (rcnt == len[rsel] - CNT_W'(1));
    assign rd_fire   = out_valid && out_ready;
    assign rd_done   = rd_fire && out_last;

    // Storage is not reset; bank_full guards every read.
    always_ff @(posedge aclk) begin
        if (wr_fire) begin
            mem[wsel][wcnt[AW-1:0]] <= rdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            wsel       <= 1'b0;
            rsel       <= 1'b0;
            wcnt       <= '0;
            rcnt       <= '0;
            bank_full  <= 2'b00;
            err_sticky <= 1'b0;
            ovf_err    <= 1'b0;
            len[0]     <= '0;
            len[1]     <= '0;
            id[0]      <= '0;
            id[1]      <= '0;
        end else begin
            // Write side
            if (wr_fire) begin
                if (wr_close) begin
                    bank_full[wsel] <= 1'b1;
                    len[wsel]       <= wcnt + CNT_W'(1);
                    id[wsel]        <= rid;
                    wsel            <= !wsel;
                    wcnt            <= '0;
                end else begin
                    wcnt <= wcnt + CNT_W'(1);
                end
            end

            // Read side; the freed bank is never the one being closed above,
            // since closing requires that bank to be empty.
            if (rd_fire) begin
                if (out_last) begin
                    bank_full[rsel] <= 1'b0;
                    rsel            <= !rsel;
                    rcnt            <= '0;
                end else begin
                    rcnt <= rcnt + CNT_W'(1);
                end
            end

            // Error flags: set has priority over clear.
            if (wr_fire && (rresp != 2'b00)) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end

            if (wr_fire && wr_wrap && !rlast) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
        end
    end

    logic unused_rd_done;
    assign unused_rd_done = rd_done;

endmodule

// File: tb/tb_ivs_dma_rd_pingpong.sv
// Directed bench for ivs_dma_rd_pingpong. Inputs change 1ns after the rising
// edge; outputs are sampled at the same point, away from the active edge.
module tb_ivs_dma_rd_pingpong;

    logic         aclk = 1'b0;
    logic         arst = 1'b1;
    logic         rvalid = 1'b0;
    logic         rready;
    logic [3:0]   rid = 4'd0;
    logic [127:0] rdata = '0;
    logic         rlast = 1'b0;
    logic [1:0]   rresp = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         out_last;
    logic [3:0]   out_id;
    logic         out_bank;
    logic [1:0]   bank_full;
    logic         err_sticky;
    logic         ovf_err;
    logic         err_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    ivs_dma_rd_pingpong #(
        .DATA_W(128),
        .DEPTH (64),
        .CNT_W (7)
    ) dut (
        .aclk      (aclk),
        .arst      (arst),
        .rvalid    (rvalid),
        .rready    (rready),
        .rid       (rid),
        .rdata     (rdata),
        .rlast     (rlast),
        .rresp     (rresp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_id    (out_id),
        .out_bank  (out_bank),
        .bank_full (bank_full),
        .err_sticky(err_sticky),
        .ovf_err   (ovf_err),
        .err_clr   (err_clr)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic apply_reset();
        arst      = 1'b1;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        rresp     = 2'b00;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        tick();
        tick();
        arst = 1'b0;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input logic [127:0] d, input logic [3:0] id_v, input logic last,
                             input logic [1:0] resp);
        int t = 0;
        rvalid = 1'b1;
        rdata  = d;
        rid    = id_v;
        rlast  = last;
        rresp  = resp;
        while (!rready && t < 400) begin
            tick();
            t++;
        end
        if (!rready) begin
            total++;
            bad++;
            $display("FAIL send_beat_timeout: rready=%0b required=1", rready);
        end
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic send_burst(input int n, input logic [127:0] base, input logic [3:0] id_v);
        for (int i = 0; i < n; i++) begin
            send_beat(base + 128'(i), id_v, (i == n - 1), 2'b00);
        end
    endtask

    // Drain n beats, checking each; optionally stall one cycle per beat.
    task automatic drain(input int n, input logic [127:0] base, input logic [3:0] id_v,
                         input logic bank, input bit stall, input string tag);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!out_valid && t < 400) begin
                tick();
                t++;
            end
            total++;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("FAIL %s_valid beat %0d: got=%0b want=1", tag, i, out_valid);
                return;
            end
            total++;
            if (out_data !== base + 128'(i)) begin
                bad++;
                $display("FAIL %s_data beat %0d: got=%0h want=%0h", tag, i, out_data,
                         base + 128'(i));
            end
            total++;
            if (out_last !== (i == n - 1)) begin
                bad++;
                $display("FAIL %s_last beat %0d: got=%0b want=%0b", tag, i, out_last,
                         (i == n - 1));
            end
            total++;
            if (out_id !== id_v || out_bank !== bank) begin
                bad++;
                $display("FAIL %s_tag beat %0d: id=%0d bank=%0b want id=%0d bank=%0b", tag, i,
                         out_id, out_bank, id_v, bank);
            end
            if (stall) begin
                logic [127:0] d_hold;
                logic         l_hold;
                d_hold = out_data;
                l_hold = out_last;
                out_ready = 1'b0;
                tick();
                total++;
                if (out_valid !== 1'b1 || out_data !== d_hold || out_last !== l_hold) begin
                    bad++;
                    $display("FAIL %s_stall beat %0d: valid=%0b data=%0h last=%0b want 1/%0h/%0b",
                             tag, i, out_valid, out_data, out_last, d_hold, l_hold);
                end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (rready !== 1'b1 || out_valid !== 1'b0 || bank_full !== 2'b00 ||
            err_sticky !== 1'b0 || ovf_err !== 1'b0) begin
            bad++;
            $display("FAIL reset: rready=%0b out_valid=%0b full=%b err=%0b ovf=%0b want 1/0/00/0/0",
                     rready, out_valid, bank_full, err_sticky, ovf_err);
        end
    endtask

    task automatic test_single_burst();
        apply_reset();
        send_burst(4, 128'h1, 4'd3);
        total++;
        if (bank_full !== 2'b01 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL single_full: full=%b valid=%0b want 01/1", bank_full, out_valid);
        end
        drain(4, 128'h1, 4'd3, 1'b0, 1'b0, "single");
        total++;
        if (bank_full !== 2'b00 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_empty: full=%b valid=%0b want 00/0", bank_full, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send_burst(8, 128'h100, 4'd1);
        send_burst(8, 128'h200, 4'd2);
        total++;
        if (bank_full !== 2'b11 || rready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_both_full: full=%b rready=%0b want 11/0", bank_full, rready);
        end
        fork
            send_burst(8, 128'h300, 4'd5);
            begin
                repeat (4) tick();
                total++;
                if (rready !== 1'b0 || bank_full !== 2'b11) begin
                    bad++;
                    $display("FAIL b2b_stall: rready=%0b full=%b want 0/11", rready, bank_full);
                end
                drain(8, 128'h100, 4'd1, 1'b0, 1'b0, "b2b_a");
                total++;
                if (rready !== 1'b1 || bank_full[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_rready_back: rready=%0b full0=%0b want 1/0", rready,
                             bank_full[0]);
                end
                drain(8, 128'h200, 4'd2, 1'b1, 1'b0, "b2b_b");
                drain(8, 128'h300, 4'd5, 1'b0, 1'b0, "b2b_c");
            end
        join
        total++;
        if (bank_full !== 2'b00) begin
            bad++;
            $display("FAIL b2b_end: full=%b want 00", bank_full);
        end
    endtask

    task automatic test_toggle_drain();
        apply_reset();
        send_burst(16, 128'h400, 4'd6);
        drain(16, 128'h400, 4'd6, 1'b0, 1'b1, "toggle");
        total++;
        if (bank_full !== 2'b00) begin
            bad++;
            $display("FAIL toggle_end: full=%b want 00", bank_full);
        end
    endtask

    task automatic test_error();
        apply_reset();
        send_beat(128'h10, 4'd4, 1'b0, 2'b00);
        send_beat(128'h11, 4'd4, 1'b0, 2'b10);
        send_beat(128'h12, 4'd4, 1'b0, 2'b00);
        send_beat(128'h13, 4'd4, 1'b1, 2'b00);
        total++;
        if (err_sticky !== 1'b1 || ovf_err !== 1'b0) begin
            bad++;
            $display("FAIL err_set: err=%0b ovf=%0b want 1/0", err_sticky, ovf_err);
        end
        drain(4, 128'h10, 4'd4, 1'b0, 1'b0, "err");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++;
        if (err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL err_clr: err=%0b want 0", err_sticky);
        end
        // Clear and a new error in the same cycle: the error stays set.
        // This is also a length-1 burst.
        err_clr = 1'b1;
        send_beat(128'h77, 4'd8, 1'b1, 2'b11);
        err_clr = 1'b0;
        total++;
        if (err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL err_set_wins: err=%0b want 1", err_sticky);
        end
        drain(1, 128'h77, 4'd8, 1'b1, 1'b0, "len1");
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 64; i++) begin
            send_beat(128'h500 + 128'(i), 4'd7, 1'b0, 2'b00);
        end
        total++;
        if (bank_full !== 2'b01 || ovf_err !== 1'b1) begin
            bad++;
            $display("FAIL ovf_close: full=%b ovf=%0b want 01/1", bank_full, ovf_err);
        end
        send_beat(128'h500 + 128'(64), 4'd7, 1'b1, 2'b00);
        total++;
        if (bank_full !== 2'b11 || err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL ovf_spill: full=%b err=%0b want 11/0", bank_full, err_sticky);
        end
        drain(64, 128'h500, 4'd7, 1'b0, 1'b0, "ovf_b0");
        drain(1, 128'h500 + 128'(64), 4'd7, 1'b1, 1'b0, "ovf_b1");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++;
        if (ovf_err !== 1'b0 || bank_full !== 2'b00) begin
            bad++;
            $display("FAIL ovf_clr: ovf=%0b full=%b want 0/00", ovf_err, bank_full);
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            send_beat(128'h900 + 128'(i), 4'd2, 1'b0, 2'b01);
        end
        total++;
        if (bank_full !== 2'b00 || out_valid !== 1'b0 || err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL mid_partial: full=%b valid=%0b err=%0b want 00/0/1", bank_full,
                     out_valid, err_sticky);
        end
        arst = 1'b1;
        tick();
        arst = 1'b0;
        total++;
        if (rready !== 1'b1 || out_valid !== 1'b0 || bank_full !== 2'b00 ||
            err_sticky !== 1'b0 || ovf_err !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: rready=%0b valid=%0b full=%b err=%0b ovf=%0b want 1/0/00/0/0",
                     rready, out_valid, bank_full, err_sticky, ovf_err);
        end
        send_burst(2, 128'h600, 4'd9);
        drain(2, 128'h600, 4'd9, 1'b0, 1'b0, "mid_after");
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_toggle_drain();
        test_error();
        test_overflow();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
